// File: rtl/mem_lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the byte-lane mask helper used by the lane aligner.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    ST_RD,
    ST_WR,
    RESP
  } state_e;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends a load value from a memory
// word, and builds the write word by merging store data into the old word.
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] wlanes;
  logic [3:0]  mask;

  always_comb begin
    case (off)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = off[1] ? word[31:16] : word[15:0];

    case (size)
      SZ_B:    load_val = {{24{byte_lane[7] & ~uns}}, byte_lane};
      SZ_H:    load_val = {{16{half_lane[15] & ~uns}}, half_lane};
      default: load_val = word;
    endcase
  end

  // Store data is replicated into every lane; the mask picks which lanes land.
  always_comb begin
    case (size)
      SZ_B:    wlanes = {4{wdata[7:0]}};
      SZ_H:    wlanes = {2{wdata[15:0]}};
      default: wlanes = wdata;
    endcase
    mask   = lane_mask(size, off);
    merged = word;
    for (int unsigned k = 0; k < 4; k++) begin
      if (mask[k]) merged[8*k +: 8] = wlanes[8*k +: 8];
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: single-outstanding core handshake in front of a
// word-addressed memory, with read-modify-write for sub-word stores.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 2048
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_a_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_e      state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] wd_q;
  logic        valid_q;
  logic        mwe_q;

  logic        illegal;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    illegal = 1'b0;
    case (size_i)
      SZ_H:    illegal = addr_i[0];
      SZ_W:    illegal = |addr_i[1:0];
      SZ_X:    illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
    if (addr_i[31:2] >= DEPTH_W) illegal = 1'b1;
  end

  mem_lane_align u_align (
    .word     (mem_rd_i),
    .off      (addr_q[1:0]),
    .size     (size_q),
    .uns      (uns_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wd_q    <= '0;
      valid_q <= 1'b0;
      mwe_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      mwe_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            size_q  <= size_i;
            uns_q   <= uns_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            err_q   <= illegal;
            if (illegal) begin
              rdata_q <= '0;
              valid_q <= 1'b1;
              state   <= RESP;
            end else if (!we_i) begin
              state <= LD;
            end else if (size_i == SZ_W) begin
              wd_q  <= wdata_i;
              mwe_q <= 1'b1;
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        LD: begin
          rdata_q <= load_val;
          valid_q <= 1'b1;
          state   <= RESP;
        end
        ST_RD: begin
          wd_q  <= merged;
          mwe_q <= 1'b1;
          state <= ST_WR;
        end
        ST_WR: begin
          valid_q <= 1'b1;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are qualified by rst_n_i so an asserted reset silences them at
  // once, including a write that would otherwise commit from ST_WR.
  assign ready_o  = rst_n_i & (state == IDLE);
  assign valid_o  = rst_n_i & valid_q;
  assign err_o    = rst_n_i & valid_q & err_q;
  assign rdata_o  = rst_n_i ? rdata_q : '0;
  assign mem_a_o  = rst_n_i ? {addr_q[31:2], 2'b00} : '0;
  assign mem_we_o = rst_n_i & mwe_q;
  assign mem_wd_o = rst_n_i ? wd_q : '0;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit that sits between the core's data port and the word-addressed `memory` block. It issues every access to that block and turns byte, halfword and word loads and stores into word-granular accesses. Sub-word stores use a read-modify-write sequence. It handles little-endian lane extraction, sign or zero extension, and alignment and range checks, and gives the core a single-outstanding req/valid handshake.

## Interface
- `DEPTH`, 2048: word count of the attached memory; word index ≥ DEPTH is an error.
- `clk_i`  in  1  clock, all state updates on rising edge.
- `rst_n_i`  in  1  synchronous active-low reset.
- `req_i`  in  1  core request; sampled only while `ready_o`=1.
- `we_i`  in  1  1 = store, 0 = load.
- `size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `uns_i`  in  1  load zero-extends when 1, sign-extends when 0.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `ready_o`  out  1  unit idle, request accepted this cycle if `req_i`=1.
- `valid_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  qualifies `valid_o`: access rejected.
- `rdata_o`  out  32  load result, held until next accept.
- `mem_a_o`  out  32  memory byte address, always `{addr[31:2],2'b00}`.
- `mem_we_o`  out  1  memory write enable.
- `mem_wd_o`  out  32  memory write data.
- `mem_rd_i`  in  32  memory read data (combinational from `mem_a_o`).

## Operation
- FSM states: IDLE, LD, ST_RD, ST_WR, RESP.
- IDLE: `ready_o`=1. On `req_i`, latch `we`, `size`, `uns`, `addr`, `wdata` and check legality.
  - Illegal if `size`=11, half with `addr[0]`=1, word with `addr[1:0]`≠0, or `addr[31:2]` ≥ DEPTH. Illegal requests go to RESP with the error flag set and make no memory access.
  - Otherwise: load → LD; word store → ST_WR; byte or half store → ST_RD.
- LD: drive `mem_a_o`. At the edge, extract the lane selected by `addr[1:0]`, extend it, and register it into `rdata_o`. Next state RESP.
- ST_RD: drive `mem_a_o`. At the edge, capture `mem_rd_i` into the merge register. Next state ST_WR.
- ST_WR: `mem_we_o`=1 and `mem_wd_o` = merged word, or the raw `wdata` for a word store. Only the addressed byte or half lanes are replaced. Next state RESP.
- RESP: `valid_o`=1, and `err_o` = latched error flag. Next state IDLE.
- Error response: `rdata_o` is forced to 0.
- Stores do not modify `rdata_o`.
- Lane rules:
  - Byte lane k = bits [8k+7:8k].
  - Half at `addr[1]`=1 uses [31:16].
  - Sign source is the MSB of the extracted lane.

## Timing
- Counting from the accept edge (edge 0), `valid_o` is high in the cycle after:
  - load: edge 1
  - word store: edge 1
  - sub-word store: edge 2
  - error: edge 0
- `mem_we_o` is high for exactly one cycle per store and is never high outside ST_WR.
- Back-to-back: `ready_o` rises in the cycle after RESP, so the next request can be accepted then. Requests made while `ready_o`=0 are ignored and must be held by the core.
- Reset: while `rst_n_i`=0, `ready_o`, `valid_o`, `err_o` and `mem_we_o` are 0, and `rdata_o`, `mem_a_o` and `mem_wd_o` are 0.
- Reset mid-operation:
  - `mem_we_o` is gated by `rst_n_i`, so a store caught in ST_WR is not written.
  - The FSM returns to IDLE and no `valid_o` is produced for the aborted access.
  - `ready_o`=1 in the first cycle after `rst_n_i` is released.

## Structure
- Package `mem_lsu_pkg`:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`
  - FSM state enum
  - `lane_mask(size, addr[1:0])` → 4-bit byte mask
- Sub-module `mem_lane_align` (combinational):
  - inputs: raw word, `addr[1:0]`, `size`, `uns`
  - outputs: extended load value and the merged store word (from old word and `wdata`)
  - used by both the LD and ST_RD/ST_WR paths.

## Test plan
All scenarios preload the memory word at 0x10 with 0x8899AABB.
- Load byte, signed, at 0x11 → `rdata_o`=0xFFFFFFAA with `valid_o` one edge after LD; same access with `uns_i`=1 → 0x000000AA. No `mem_we_o`.
- Byte store of 0x5C at 0x12 → one read cycle then one write cycle, word becomes 0x885CAABB; `valid_o` two edges after LD-equivalent timing (3rd cycle after accept).
- Half store of 0x1234 at 0x12 → 0x1234AABB; then a signed half load at 0x10 → 0xFFFFAABB.
- Word store at 0x13, or a byte load at address 4×DEPTH → `valid_o`=`err_o`=1 in the cycle after accept, no memory write, `rdata_o`=0.
- `rst_n_i` pulled low during ST_WR of a word store of 0xDEADBEEF to 0x10 → memory unchanged, no `valid_o`, `ready_o`=1 in the first cycle after release.
- `req_i` held high across 4 word loads at 0x0, 0x4, 0x8 and 0xC → each accepted in the cycle after the previous RESP, four `valid_o` pulses carrying the preloaded values in order.
